// File: rtl/keypad_matrix_scanner.sv
// Row/column keypad scanner with press/release debounce and a valid/ready key output.
// Optional auto-repeat is enabled by defining KEYPAD_REPEAT_EN.
module keypad_matrix_scanner #(
    parameter int N_ROWS        = 4,
    parameter int N_COLS        = 4,
    parameter int SCAN_DIV      = 4,
    parameter int DEBOUNCE_CYC  = 8,
    parameter int REPEAT_DELAY  = 1000,
    parameter int REPEAT_PERIOD = 250,
    localparam int CODE_W       = $clog2(N_ROWS * N_COLS)
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              scan_en,
    input  logic [N_ROWS-1:0] row_in,
    output logic [N_COLS-1:0] col_drive,
    output logic [CODE_W-1:0] key_code,
    output logic              key_valid,
    input  logic              key_ready,
    output logic              key_down,
    output logic              key_repeat,
    output logic              overrun,
    input  logic              overrun_clr
);
    localparam int ROW_W = $clog2(N_ROWS);
    localparam int COL_W = $clog2(N_COLS);
    localparam int DIV_W = $clog2(SCAN_DIV);
    localparam int DB_W  = $clog2(DEBOUNCE_CYC + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYC - 1);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(N_COLS - 1);

    typedef enum logic [1:0] {ST_SCAN, ST_PRESS_DB, ST_HELD} state_t;

    state_t             r_state, w_state_nxt;
    logic [N_ROWS-1:0]  r_rs_meta, r_rs;
    logic [COL_W-1:0]   r_col, w_col_nxt, w_col_inc;
    logic [ROW_W-1:0]   r_row, w_row_nxt, w_hit_row;
    logic [DIV_W-1:0]   r_div, w_div_nxt;
    logic [DB_W-1:0]    r_db, w_db_nxt;
    logic               r_en;
    logic [CODE_W-1:0]  r_key_code, w_code;
    logic               r_key_valid, r_overrun;
    logic               w_hit, w_sel, w_event, w_event_rep, w_any_evt, w_load;

`ifdef KEYPAD_REPEAT_EN
    localparam int REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int REP_W   = $clog2(REP_MAX + 1);
    localparam logic [REP_W-1:0] REP_DLY_LAST = REP_W'(REPEAT_DELAY - 1);
    localparam logic [REP_W-1:0] REP_PER_LAST = REP_W'(REPEAT_PERIOD - 1);
    logic [REP_W-1:0] r_rep, w_rep_nxt;
    logic             r_rep_first, w_rep_first_nxt;
    logic             r_key_repeat;
`else
    logic w_unused_rep;
    assign w_unused_rep = (REPEAT_DELAY > 0) ^ (REPEAT_PERIOD > 0);
`endif

    // Lowest active row wins when several rows are high on the sampled column.
    always_comb begin
        w_hit     = 1'b0;
        w_hit_row = '0;
        for (int unsigned i = 0; i < N_ROWS; i++) begin
            if (r_rs[i] && !w_hit) begin
                w_hit     = 1'b1;
                w_hit_row = ROW_W'(i);
            end
        end
    end

    assign w_sel     = r_rs[r_row];
    assign w_col_inc = (r_col == COL_LAST) ? '0 : r_col + COL_W'(1);
    assign w_code    = CODE_W'(r_row) * CODE_W'(N_COLS) + CODE_W'(r_col);

    always_comb begin
        w_state_nxt = r_state;
        w_col_nxt   = r_col;
        w_row_nxt   = r_row;
        w_div_nxt   = r_div;
        w_db_nxt    = r_db;
        w_event     = 1'b0;
        w_event_rep = 1'b0;
`ifdef KEYPAD_REPEAT_EN
        w_rep_nxt       = r_rep;
        w_rep_first_nxt = r_rep_first;
`endif
        // r_en gates the first enabled cycle so column 0 still gets a full dwell.
        if (!scan_en || !r_en) begin
            w_state_nxt = ST_SCAN;
            w_col_nxt   = '0;
            w_div_nxt   = '0;
            w_db_nxt    = '0;
`ifdef KEYPAD_REPEAT_EN
            w_rep_nxt       = '0;
            w_rep_first_nxt = 1'b1;
`endif
        end else begin
            case (r_state)
                ST_SCAN: begin
                    if (r_div == DIV_LAST) begin
                        w_div_nxt = '0;
                        if (w_hit) begin
                            w_state_nxt = ST_PRESS_DB;
                            w_row_nxt   = w_hit_row;
                            w_db_nxt    = '0;
                        end else begin
                            w_col_nxt = w_col_inc;
                        end
                    end else begin
                        w_div_nxt = r_div + DIV_W'(1);
                    end
                end
                ST_PRESS_DB: begin
                    if (!w_sel) begin
                        w_state_nxt = ST_SCAN;
                        w_div_nxt   = '0;
                        w_db_nxt    = '0;
                    end else if (r_db == DB_LAST) begin
                        w_event     = 1'b1;
                        w_state_nxt = ST_HELD;
                        w_db_nxt    = '0;
`ifdef KEYPAD_REPEAT_EN
                        w_rep_nxt       = '0;
                        w_rep_first_nxt = 1'b1;
`endif
                    end else begin
                        w_db_nxt = r_db + DB_W'(1);
                    end
                end
                ST_HELD: begin
                    if (w_sel) begin
                        w_db_nxt = '0;
                    end else if (r_db == DB_LAST) begin
                        w_state_nxt = ST_SCAN;
                        w_col_nxt   = w_col_inc;
                        w_div_nxt   = '0;
                        w_db_nxt    = '0;
                    end else begin
                        w_db_nxt = r_db + DB_W'(1);
                    end
`ifdef KEYPAD_REPEAT_EN
                    // Repeat timing freezes during release debounce and restarts on a re-press.
                    if (w_sel) begin
                        if (r_db != '0) begin
                            w_rep_nxt       = '0;
                            w_rep_first_nxt = 1'b1;
                        end else if (r_rep == (r_rep_first ? REP_DLY_LAST : REP_PER_LAST)) begin
                            w_event_rep     = 1'b1;
                            w_rep_nxt       = '0;
                            w_rep_first_nxt = 1'b0;
                        end else begin
                            w_rep_nxt = r_rep + REP_W'(1);
                        end
                    end
`endif
                end
                default: w_state_nxt = ST_SCAN;
            endcase
        end
    end

    assign w_any_evt = w_event | w_event_rep;
    assign w_load    = w_any_evt & (~r_key_valid | key_ready);

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_rs_meta   <= '0;
            r_rs        <= '0;
            r_state     <= ST_SCAN;
            r_col       <= '0;
            r_row       <= '0;
            r_div       <= '0;
            r_db        <= '0;
            r_en        <= 1'b1;
            r_key_code  <= '0;
            r_key_valid <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_rs_meta <= row_in;
            r_rs      <= r_rs_meta;
            r_state   <= w_state_nxt;
            r_col     <= w_col_nxt;
            r_row     <= w_row_nxt;
            r_div     <= w_div_nxt;
            r_db      <= w_db_nxt;
            r_en      <= scan_en;
            if (w_load) begin
                r_key_code  <= w_code;
                r_key_valid <= 1'b1;
            end else if (r_key_valid && key_ready) begin
                r_key_valid <= 1'b0;
            end
            if (w_any_evt && !w_load) begin
                r_overrun <= 1'b1;
            end else if (overrun_clr) begin
                r_overrun <= 1'b0;
            end
        end
    end

`ifdef KEYPAD_REPEAT_EN
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_rep        <= '0;
            r_rep_first  <= 1'b1;
            r_key_repeat <= 1'b0;
        end else begin
            r_rep       <= w_rep_nxt;
            r_rep_first <= w_rep_first_nxt;
            if (w_load) begin
                r_key_repeat <= w_event_rep;
            end
        end
    end
    assign key_repeat = r_key_repeat;
`else
    assign key_repeat = 1'b0;
`endif

    assign col_drive = r_en ? ({{(N_COLS-1){1'b0}}, 1'b1} << r_col) : '0;
    assign key_code  = r_key_code;
    assign key_valid = r_key_valid;
    assign key_down  = (r_state == ST_HELD);
    assign overrun   = r_overrun;

endmodule

// File: tb/tb_keypad_matrix_scanner.sv
// Scoreboard bench for keypad_matrix_scanner on a 4x4 keypad model.
// Define KEYPAD_REPEAT_EN to also cover auto-repeat timing.
module tb_keypad_matrix_scanner;
    logic        CLK = 1'b0;
    logic        RESET;
    logic        scan_en;
    logic [3:0]  row_in;
    logic [3:0]  col_drive;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_ready;
    logic        key_down;
    logic        key_repeat;
    logic        overrun;
    logic        overrun_clr;

    logic [15:0] keys;
    logic [4:0]  sb_q[$];
    int          evt_cyc[$];
    int          n_cmp = 0;
    int          n_err = 0;
    int          n_evt = 0;
    int          cyc   = 0;
    bit          ignore_rep = 1'b0;

    keypad_matrix_scanner #(
        .N_ROWS(4), .N_COLS(4), .SCAN_DIV(4), .DEBOUNCE_CYC(8),
        .REPEAT_DELAY(20), .REPEAT_PERIOD(10)
    ) dut (
        .CLK(CLK), .RESET(RESET), .scan_en(scan_en), .row_in(row_in),
        .col_drive(col_drive), .key_code(key_code), .key_valid(key_valid),
        .key_ready(key_ready), .key_down(key_down), .key_repeat(key_repeat),
        .overrun(overrun), .overrun_clr(overrun_clr)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    // Key index equals its code: keys[row*4 + col] shorts row to col.
    always_comb begin
        row_in = '0;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (keys[r*4+c] && col_drive[c]) row_in[r] = 1'b1;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    always @(negedge CLK) begin
        if (!RESET && key_valid && key_ready && !(ignore_rep && key_repeat)) begin
            logic [31:0] exp;
            exp = (sb_q.size() > 0) ? 32'(sb_q.pop_front()) : 32'hFFFF_FFFF;
            check_eq("event", {27'd0, key_repeat, key_code}, exp);
            n_evt++;
            evt_cyc.push_back(cyc);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic wait_down(input logic val, input string tag);
        for (int i = 0; i < 80 && key_down !== val; i++) tick(1);
        check_eq(tag, key_down, val);
    endtask

    task automatic wait_col(input logic [3:0] val, input string tag);
        for (int i = 0; i < 40 && col_drive !== val; i++) tick(1);
        check_eq(tag, col_drive, val);
    endtask

    task automatic tap(input int code);
        keys[code] = 1'b1;
        wait_down(1'b1, "tap_down");
        keys[code] = 1'b0;
        wait_down(1'b0, "tap_up");
    endtask

    initial begin
        int n;
        int base;
        RESET = 1'b1; scan_en = 1'b1; key_ready = 1'b1; overrun_clr = 1'b0; keys = '0;
        tick(3);
        check_eq("rst_col", col_drive, 4'b0001);
        check_eq("rst_valid", key_valid, 0);
        check_eq("rst_code", key_code, 0);
        check_eq("rst_down", key_down, 0);
        check_eq("rst_rep", key_repeat, 0);
        check_eq("rst_ovr", overrun, 0);
        RESET = 1'b0;

        for (int i = 0; i < 20; i++) begin
            check_eq("idle_col", col_drive, 4'b0001 << ((i / 4) % 4));
            tick(1);
        end
        check_eq("idle_valid", key_valid, 0);

        // Single press of code 9, release debounce latency, resume at next column.
        ignore_rep = 1'b0;
`ifdef KEYPAD_REPEAT_EN
        ignore_rep = 1'b1;
`endif
        sb_q.push_back(5'd9);
        keys[9] = 1'b1;
        tick(40);
        check_eq("held_down", key_down, 1);
        keys[9] = 1'b0;
        n = 0;
        while (key_down && n < 40) begin tick(1); n++; end
        check_eq("rel_latency", n, 10);
        check_eq("resume_col2", col_drive, 4'b0100);
        tick(5);

        // Bounce on code 3 must never produce an event.
        base = n_evt;
        for (int i = 0; i < 20; i++) begin
            keys[3] = 1'b1; tick(3);
            keys[3] = 1'b0; tick(2);
        end
        tick(10);
        check_eq("bounce_noevt", n_evt, base);
        sb_q.push_back(5'd3);
        tap(3);
        tick(3);

        // Back-pressure: second event dropped, overrun sticky until cleared.
        key_ready = 1'b0;
        sb_q.push_back(5'd5);
        tap(5);
        check_eq("bp_valid", key_valid, 1);
        check_eq("bp_code5", key_code, 5);
        check_eq("bp_ovr0", overrun, 0);
        tap(10);
        check_eq("bp_code_hold", key_code, 5);
        check_eq("bp_ovr1", overrun, 1);
        key_ready = 1'b1;
        tick(1);
        check_eq("bp_accepted", key_valid, 0);
        check_eq("bp_ovr_sticky", overrun, 1);
        overrun_clr = 1'b1; tick(1); overrun_clr = 1'b0;
        check_eq("ovr_cleared", overrun, 0);

        // Rows 1 and 3 on column 0: lowest row wins.
        sb_q.push_back(5'd4);
        keys[4] = 1'b1; keys[12] = 1'b1;
        wait_down(1'b1, "multi_down");
        keys[4] = 1'b0; keys[12] = 1'b0;
        wait_down(1'b0, "multi_up");
        tick(2);

        // scan_en low: columns off, key_down dropped, pending key kept.
        key_ready = 1'b0;
        sb_q.push_back(5'd1);
        keys[1] = 1'b1;
        wait_down(1'b1, "scanen_down");
        scan_en = 1'b0;
        tick(1);
        check_eq("scanoff_col", col_drive, 4'b0000);
        check_eq("scanoff_down", key_down, 0);
        check_eq("scanoff_valid", key_valid, 1);
        check_eq("scanoff_code", key_code, 1);
        tick(8);
        check_eq("scanoff_hold", col_drive, 4'b0000);
        keys[1] = 1'b0;
        scan_en = 1'b1;
        tick(1);
        check_eq("scanon_col0", col_drive, 4'b0001);
        key_ready = 1'b1;
        tick(2);

        // RESET during press debounce of code 6 aborts without an event.
        wait_col(4'b0001, "rst_wait_c0");
        keys[6] = 1'b1;
        wait_col(4'b0100, "rst_wait_c2");
        tick(6);
        base = n_evt;
        RESET = 1'b1;
        tick(1);
        check_eq("midrst_col", col_drive, 4'b0001);
        check_eq("midrst_code", key_code, 0);
        check_eq("midrst_valid", key_valid, 0);
        check_eq("midrst_down", key_down, 0);
        check_eq("midrst_ovr", overrun, 0);
        keys[6] = 1'b0;
        RESET = 1'b0;
        tick(30);
        check_eq("midrst_noevt", n_evt, base);

`ifdef KEYPAD_REPEAT_EN
        // Hold code 0: first event, then repeats at +20, +30, +40, +50.
        ignore_rep = 1'b0;
        base = n_evt;
        sb_q.push_back(5'd0);
        for (int i = 0; i < 4; i++) sb_q.push_back(5'h10);
        keys[0] = 1'b1;
        wait_down(1'b1, "rep_down");
        tick(55);
        keys[0] = 1'b0;
        wait_down(1'b0, "rep_up");
        tick(5);
        check_eq("rep_count", n_evt - base, 5);
        if (evt_cyc.size() >= base + 5) begin
            check_eq("rep_first_gap", evt_cyc[base+1] - evt_cyc[base], 20);
            for (int i = 2; i < 5; i++)
                check_eq("rep_period", evt_cyc[base+i] - evt_cyc[base+i-1], 10);
        end
`endif

        check_eq("sb_drained", sb_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
